// File: rtl/icmp_ping_tx.sv
// -----------------------------------------------------------------------------
// icmp_ping_tx
//   Builds and transmits one ICMP echo request (Ethernet II / IPv4 / ICMP) on a
//   GMII transmit port, then waits for the matching echo reply or a timeout.
//
//   Ports
//     clk, rst_n        GMII transmit clock, asynchronous active-low reset
//     ping_start        one-cycle request; accepted only while idle
//     pc_mac, pc_ip     destination addresses, latched when a request is taken
//     rx_reply_valid    echo-reply pulse from the receive parser
//     rx_identify/_sequence  identifier / sequence of that reply
//     gmii_eth_txc/_txctl/_txd  GMII transmit clock, enable and data
//     busy              high whenever the engine is not idle
//     ping_ok           one-cycle pulse on a matching reply
//     ping_timeout      one-cycle pulse when the reply wait expires
//     seq_out           sequence number of the current / next request
// -----------------------------------------------------------------------------
module icmp_ping_tx #(
  parameter logic [47:0] BOARD_MAC   = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP    = 32'hC0_A8_01_0A,
  parameter logic [15:0] IDENTIFY    = 16'h1234,
  parameter int unsigned PAYLOAD_LEN = 32,
  parameter int unsigned TIMEOUT_CYC = 125_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ping_start,
  input  logic [47:0] pc_mac,
  input  logic [31:0] pc_ip,
  input  logic        rx_reply_valid,
  input  logic [15:0] rx_identify,
  input  logic [15:0] rx_sequence,
  output logic        gmii_eth_txc,
  output logic        gmii_eth_txctl,
  output logic [7:0]  gmii_eth_txd,
  output logic        busy,
  output logic        ping_ok,
  output logic        ping_timeout,
  output logic [15:0] seq_out
);

  typedef enum logic [3:0] {
    IDLE, PREP, PREAMBLE, ETH_HDR, IP_HDR, ICMP_HDR, PAYLOAD, FCS, IFG, WAIT_REPLY
  } state_t;

  // Ones-complement sum of the payload words; the payload pattern (byte i =
  // i mod 256) is fixed, so this folds to a constant at elaboration.
  function automatic logic [31:0] payload_sum(input int unsigned len);
    logic [31:0] s;
    logic [7:0]  hi;
    logic [7:0]  lo;
    s = '0;
    for (int unsigned i = 0; i < len; i += 2) begin
      hi = 8'(i);
      lo = (i + 1 < len) ? 8'(i + 1) : 8'h00;
      s  = s + {16'h0000, hi, lo};
    end
    return s;
  endfunction

  // Two end-around-carry folds bring any 32-bit partial sum into 16 bits.
  function automatic logic [15:0] csum_fold(input logic [31:0] s);
    logic [31:0] t;
    t = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    t = {16'h0000, t[15:0]} + {16'h0000, t[31:16]};
    return ~t[15:0];
  endfunction

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  localparam logic [15:0] TOTAL_LEN      = 16'(28 + PAYLOAD_LEN);
  localparam logic [10:0] PL_LEN         = 11'(PAYLOAD_LEN);
  localparam logic [31:0] TMO_LAST       = 32'(TIMEOUT_CYC - 1);
  // Address-independent part of the IPv4 header sum (checksum field is 0).
  localparam logic [31:0] IP_CONST_SUM   = 32'h4500 + 32'(TOTAL_LEN) + 32'h4000 + 32'h4001
                                         + 32'(BOARD_IP[31:16]) + 32'(BOARD_IP[15:0]);
  localparam logic [31:0] ICMP_CONST_SUM = 32'h0800 + 32'(IDENTIFY) + payload_sum(PAYLOAD_LEN);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [15:0] seq_q, seq_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] ip_q, ip_d;
  logic [31:0] ip_sum_q, ip_sum_d;
  logic [31:0] icmp_sum_q, icmp_sum_d;
  logic [15:0] ip_csum_q, ip_csum_d;
  logic [15:0] icmp_csum_q, icmp_csum_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        txctl_q, txctl_d;
  logic        ping_ok_q, ping_ok_d;
  logic        ping_timeout_q, ping_timeout_d;

  logic [111:0] eth_hdr;
  logic [159:0] ip_hdr;
  logic [63:0]  icmp_hdr;
  logic [31:0]  fcs_word;

  logic [7:0]  tx_byte;
  logic        seg_step;
  logic [10:0] seg_len;
  state_t      seg_next;
  logic        reply_match;

  assign eth_hdr  = {mac_q, BOARD_MAC, 16'h0800};
  assign ip_hdr   = {16'h4500, TOTAL_LEN, seq_q, 16'h4000, 8'h40, 8'h01,
                     ip_csum_q, BOARD_IP, ip_q};
  assign icmp_hdr = {8'h08, 8'h00, icmp_csum_q, IDENTIFY, seq_q};
  assign fcs_word = ~crc_q;

  assign reply_match = rx_reply_valid && (rx_identify == IDENTIFY) && (rx_sequence == seq_q);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tmo_d          = tmo_q;
    seq_d          = seq_q;
    mac_d          = mac_q;
    ip_d           = ip_q;
    ip_sum_d       = ip_sum_q;
    icmp_sum_d     = icmp_sum_q;
    ip_csum_d      = ip_csum_q;
    icmp_csum_d    = icmp_csum_q;
    crc_d          = crc_q;
    txctl_d        = 1'b0;
    ping_ok_d      = 1'b0;
    ping_timeout_d = 1'b0;
    tx_byte        = 8'h00;
    seg_step       = 1'b0;
    seg_len        = 11'd1;
    seg_next       = state_q;

    case (state_q)
      IDLE: begin
        if (ping_start) begin
          mac_d   = pc_mac;
          ip_d    = pc_ip;
          cnt_d   = '0;
          state_d = PREP;
        end
      end
      PREP: begin
        // Cycle 0 accumulates, cycle 1 folds and inverts.
        seg_step = 1'b1;
        seg_len  = 11'd2;
        seg_next = PREAMBLE;
        crc_d    = '1;
        if (cnt_q == 11'd0) begin
          ip_sum_d   = IP_CONST_SUM + 32'(seq_q) + 32'(ip_q[31:16]) + 32'(ip_q[15:0]);
          icmp_sum_d = ICMP_CONST_SUM + 32'(seq_q);
        end else begin
          ip_csum_d   = csum_fold(ip_sum_q);
          icmp_csum_d = csum_fold(icmp_sum_q);
        end
      end
      PREAMBLE: begin
        seg_step = 1'b1;
        seg_len  = 11'd8;
        seg_next = ETH_HDR;
        txctl_d  = 1'b1;
        tx_byte  = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
      end
      ETH_HDR: begin
        seg_step = 1'b1;
        seg_len  = 11'd14;
        seg_next = IP_HDR;
        txctl_d  = 1'b1;
        tx_byte  = eth_hdr[8*(13 - int'(cnt_q)) +: 8];
      end
      IP_HDR: begin
        seg_step = 1'b1;
        seg_len  = 11'd20;
        seg_next = ICMP_HDR;
        txctl_d  = 1'b1;
        tx_byte  = ip_hdr[8*(19 - int'(cnt_q)) +: 8];
      end
      ICMP_HDR: begin
        seg_step = 1'b1;
        seg_len  = 11'd8;
        seg_next = PAYLOAD;
        txctl_d  = 1'b1;
        tx_byte  = icmp_hdr[8*(7 - int'(cnt_q)) +: 8];
      end
      PAYLOAD: begin
        seg_step = 1'b1;
        seg_len  = PL_LEN;
        seg_next = FCS;
        txctl_d  = 1'b1;
        tx_byte  = cnt_q[7:0];
      end
      FCS: begin
        seg_step = 1'b1;
        seg_len  = 11'd4;
        seg_next = IFG;
        txctl_d  = 1'b1;
        tx_byte  = fcs_word[8*int'(cnt_q[1:0]) +: 8];
      end
      IFG: begin
        seg_step = 1'b1;
        seg_len  = 11'd12;
        seg_next = WAIT_REPLY;
        tmo_d    = '0;
      end
      WAIT_REPLY: begin
        tmo_d = tmo_q + 32'd1;
        // A match on the deadline cycle takes priority over the timeout.
        if (reply_match) begin
          ping_ok_d = 1'b1;
          seq_d     = seq_q + 16'd1;
          state_d   = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          ping_timeout_d = 1'b1;
          seq_d          = seq_q + 16'd1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CRC covers destination MAC through the last payload byte.
    if (state_q inside {ETH_HDR, IP_HDR, ICMP_HDR, PAYLOAD})
      crc_d = crc_byte(crc_q, tx_byte);

    if (seg_step) begin
      if (cnt_q == seg_len - 11'd1) begin
        state_d = seg_next;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 11'd1;
      end
    end

    txd_d = tx_byte;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tmo_q          <= '0;
      seq_q          <= '0;
      mac_q          <= '0;
      ip_q           <= '0;
      ip_sum_q       <= '0;
      icmp_sum_q     <= '0;
      ip_csum_q      <= '0;
      icmp_csum_q    <= '0;
      crc_q          <= '0;
      txd_q          <= '0;
      txctl_q        <= 1'b0;
      ping_ok_q      <= 1'b0;
      ping_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      seq_q          <= seq_d;
      mac_q          <= mac_d;
      ip_q           <= ip_d;
      ip_sum_q       <= ip_sum_d;
      icmp_sum_q     <= icmp_sum_d;
      ip_csum_q      <= ip_csum_d;
      icmp_csum_q    <= icmp_csum_d;
      crc_q          <= crc_d;
      txd_q          <= txd_d;
      txctl_q        <= txctl_d;
      ping_ok_q      <= ping_ok_d;
      ping_timeout_q <= ping_timeout_d;
    end
  end

  assign gmii_eth_txc   = clk;
  assign gmii_eth_txctl = txctl_q;
  assign gmii_eth_txd   = txd_q;
  assign busy           = (state_q != IDLE);
  assign ping_ok        = ping_ok_q;
  assign ping_timeout   = ping_timeout_q;
  assign seq_out        = seq_q;

endmodule

// File: tb/tb_icmp_ping_tx.sv
// -----------------------------------------------------------------------------
// tb_icmp_ping_tx
//   Self-checking bench for icmp_ping_tx. A reference model builds each frame
//   byte by byte, including both checksums and the CRC, and pushes it into a
//   scoreboard queue when the request is driven; bytes are popped and
//   compared as the DUT transmits them. A short reply timeout keeps run time low.
// -----------------------------------------------------------------------------
module tb_icmp_ping_tx;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A;
  localparam logic [15:0] IDENTIFY  = 16'h1234;
  localparam int          PL        = 32;
  localparam int          TMO       = 300;
  localparam int          FRAME_LEN = 8 + 14 + 20 + 8 + PL + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ping_start = 1'b0;
  logic [47:0] pc_mac = '0;
  logic [31:0] pc_ip = '0;
  logic        rx_reply_valid = 1'b0;
  logic [15:0] rx_identify = '0;
  logic [15:0] rx_sequence = '0;
  logic        gmii_eth_txc;
  logic        gmii_eth_txctl;
  logic [7:0]  gmii_eth_txd;
  logic        busy;
  logic        ping_ok;
  logic        ping_timeout;
  logic [15:0] seq_out;

  icmp_ping_tx #(.TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ping_start     (ping_start),
    .pc_mac         (pc_mac),
    .pc_ip          (pc_ip),
    .rx_reply_valid (rx_reply_valid),
    .rx_identify    (rx_identify),
    .rx_sequence    (rx_sequence),
    .gmii_eth_txc   (gmii_eth_txc),
    .gmii_eth_txctl (gmii_eth_txctl),
    .gmii_eth_txd   (gmii_eth_txd),
    .busy           (busy),
    .ping_ok        (ping_ok),
    .ping_timeout   (ping_timeout),
    .seq_out        (seq_out)
  );

  always #4 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cap[$];
  logic [15:0] seq_model = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: preamble, headers, payload, FCS pushed to the scoreboard.
  task automatic build_frame(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] seq);
    logic [7:0]  d[$];
    logic [47:0] bm;
    logic [31:0] bi;
    logic [31:0] s;
    logic [31:0] crc;
    logic [15:0] ck;
    logic [15:0] tl;
    logic [7:0]  b;
    logic [7:0]  lo;
    bm = BOARD_MAC;
    bi = BOARD_IP;
    tl = 16'(28 + PL);
    for (int i = 5; i >= 0; i--) d.push_back(mac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) d.push_back(bm[8*i +: 8]);
    d.push_back(8'h08); d.push_back(8'h00);
    d.push_back(8'h45); d.push_back(8'h00); d.push_back(tl[15:8]); d.push_back(tl[7:0]);
    d.push_back(seq[15:8]); d.push_back(seq[7:0]); d.push_back(8'h40); d.push_back(8'h00);
    d.push_back(8'h40); d.push_back(8'h01); d.push_back(8'h00); d.push_back(8'h00);
    for (int i = 3; i >= 0; i--) d.push_back(bi[8*i +: 8]);
    for (int i = 3; i >= 0; i--) d.push_back(ip[8*i +: 8]);
    d.push_back(8'h08); d.push_back(8'h00); d.push_back(8'h00); d.push_back(8'h00);
    d.push_back(IDENTIFY[15:8]); d.push_back(IDENTIFY[7:0]);
    d.push_back(seq[15:8]); d.push_back(seq[7:0]);
    for (int i = 0; i < PL; i++) d.push_back(8'(i));

    s = '0;
    for (int i = 14; i < 34; i += 2) s = s + 32'({d[i], d[i+1]});
    while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
    ck = ~s[15:0];
    d[24] = ck[15:8]; d[25] = ck[7:0];

    s = '0;
    for (int i = 34; i < d.size(); i += 2) begin
      lo = (i + 1 < d.size()) ? d[i+1] : 8'h00;
      s  = s + 32'({d[i], lo});
    end
    while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
    ck = ~s[15:0];
    d[36] = ck[15:8]; d[37] = ck[7:0];

    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < d.size(); i++) begin
      b = d[i];
      for (int k = 0; k < 8; k++) begin
        if (crc[0] != b[k]) crc = (crc >> 1) ^ 32'hEDB8_8320;
        else                crc = crc >> 1;
      end
    end
    crc = ~crc;

    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < d.size(); i++) exp_q.push_back(d[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
  endtask

  // Request a ping and compare the transmitted frame. rst_at >= 0 pulses reset
  // when that byte index is on the wire.
  task automatic run_frame(input logic [47:0] mac, input logic [31:0] ip,
                           input bit hold, input int rst_at);
    int lat;
    int n;
    bit saw_ok;
    bit aborted;
    exp_q.delete();
    cap.delete();
    build_frame(mac, ip, seq_model);
    @(negedge clk);
    ping_start = 1'b1; pc_mac = mac; pc_ip = ip;
    @(negedge clk);
    if (!hold) ping_start = 1'b0;
    lat = 1;
    while (!gmii_eth_txctl && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first_byte_latency", 64'(lat), 64'd4);
    n = 0; saw_ok = 1'b0; aborted = 1'b0;
    while (gmii_eth_txctl && n < 2000) begin
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_txctl", 64'(gmii_eth_txctl), 64'd0);
        check("rst_txd", 64'(gmii_eth_txd), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_seq", 64'(seq_out), 64'd0);
        aborted = 1'b1;
        exp_q.delete();
        seq_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      // A matching reply while transmitting must be ignored.
      rx_reply_valid = (n == 10);
      rx_identify    = IDENTIFY;
      rx_sequence    = seq_model;
      saw_ok |= ping_ok;
      cap.push_back(gmii_eth_txd);
      if (exp_q.size() > 0) check($sformatf("byte%0d", n), 64'(gmii_eth_txd), 64'(exp_q.pop_front()));
      n++;
      @(negedge clk);
    end
    rx_reply_valid = 1'b0;
    ping_start = 1'b0;
    if (!aborted) begin
      check("frame_len", 64'(n), 64'(FRAME_LEN));
      check("scoreboard_left", 64'(exp_q.size()), 64'd0);
      check("no_ok_during_tx", 64'(saw_ok), 64'd0);
    end
  endtask

  // Called on the first low-txctl negedge after a frame.
  task automatic reply_ok();
    repeat (15) @(negedge clk);
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_txd_idle", 64'({gmii_eth_txctl, gmii_eth_txd}), 64'd0);
    rx_reply_valid = 1'b1; rx_identify = IDENTIFY; rx_sequence = seq_model;
    @(negedge clk);
    rx_reply_valid = 1'b0;
    seq_model = seq_model + 16'd1;
    check("reply_ping_ok", 64'(ping_ok), 64'd1);
    check("reply_busy", 64'(busy), 64'd0);
    check("reply_seq", 64'(seq_out), 64'(seq_model));
    @(negedge clk);
    check("ping_ok_one_cycle", 64'(ping_ok), 64'd0);
  endtask

  // Observe the wait window; good_at > 0 drives a matching reply then.
  task automatic wait_end(input int bad_at, input int good_at);
    int k, ok_at, to_at, n_ok, n_to, n_tx;
    k = 0; ok_at = -1; to_at = -1; n_ok = 0; n_to = 0; n_tx = 0;
    while (k < TMO + 40) begin
      @(negedge clk);
      k++;
      rx_reply_valid = 1'b0;
      if (ping_ok) begin n_ok++; if (ok_at < 0) ok_at = k; end
      if (ping_timeout) begin n_to++; if (to_at < 0) to_at = k; end
      if (gmii_eth_txctl) n_tx++;
      if (k == bad_at) begin
        rx_reply_valid = 1'b1; rx_identify = IDENTIFY; rx_sequence = 16'h0005;
      end
      if (k == bad_at + 3) begin
        rx_reply_valid = 1'b1; rx_identify = 16'h4321; rx_sequence = seq_model;
      end
      if (k == good_at) begin
        rx_reply_valid = 1'b1; rx_identify = IDENTIFY; rx_sequence = seq_model;
      end
    end
    rx_reply_valid = 1'b0;
    seq_model = seq_model + 16'd1;
    if (good_at > 0) begin
      check("deadline_ok_at", 64'(ok_at), 64'(TMO + 11));
      check("deadline_ok_count", 64'(n_ok), 64'd1);
      check("deadline_no_timeout", 64'(n_to), 64'd0);
    end else begin
      check("timeout_at", 64'(to_at), 64'(TMO + 11));
      check("timeout_count", 64'(n_to), 64'd1);
      check("timeout_no_ok", 64'(n_ok), 64'd0);
    end
    check("wait_no_second_frame", 64'(n_tx), 64'd0);
    check("end_seq", 64'(seq_out), 64'(seq_model));
    check("end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_txctl", 64'(gmii_eth_txctl), 64'd0);
    check("reset_txd", 64'(gmii_eth_txd), 64'd0);
    check("reset_flags", 64'({busy, ping_ok, ping_timeout}), 64'd0);
    check("reset_seq", 64'(seq_out), 64'd0);
    rst_n = 1'b1;

    // Broadcast MAC to 192.168.1.102, answered with a matching reply.
    run_frame(48'hFF_FF_FF_FF_FF_FF, 32'hC0_A8_01_66, 1'b0, -1);
    check("ip_total_len", 64'({cap[24], cap[25]}), 64'h003C);
    check("ip_ident_first", 64'({cap[26], cap[27]}), 64'h0000);
    reply_ok();

    // Non-matching replies only: timeout.
    run_frame(48'h02_AB_CD_EF_01_23, 32'h0A_00_00_05, 1'b0, -1);
    wait_end(20, -1);

    // ping_start held through the frame; matching reply on the deadline cycle.
    run_frame(48'h3C_97_0E_11_22_33, 32'hC0_A8_01_FE, 1'b1, -1);
    wait_end(30, TMO + 10);

    // Sequence wrap from 0xFFFF.
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut.seq_q;
    seq_model = 16'hFFFF;
    @(negedge clk);
    check("forced_seq", 64'(seq_out), 64'hFFFF);
    run_frame(48'hA0_B1_C2_D3_E4_F5, 32'hAC_10_00_01, 1'b0, -1);
    reply_ok();
    check("wrapped_seq", 64'(seq_out), 64'h0000);
    run_frame(48'hA0_B1_C2_D3_E4_F5, 32'hAC_10_00_01, 1'b0, -1);
    check("ip_ident_after_wrap", 64'({cap[26], cap[27]}), 64'h0000);
    reply_ok();

    // Reset mid-frame, then a clean frame with sequence 0.
    run_frame(48'h11_22_33_44_55_66, 32'hC0_A8_01_02, 1'b0, 40);
    run_frame(48'h11_22_33_44_55_66, 32'hC0_A8_01_02, 1'b0, -1);
    check("ip_ident_after_reset", 64'({cap[26], cap[27]}), 64'h0000);
    reply_ok();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
